// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
package bcd_pkg;

  localparam int                 NIB_W   = 4;
  localparam logic [NIB_W-1:0]   BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_to_bin_mac10.sv
// Combinational multiply-by-ten-and-add step: result = acc*10 + digit.
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int BW = 14
) (
  input  logic [BW-1:0]    acc,
  input  logic [NIB_W-1:0] digit,
  output logic [BW-1:0]    result
);

  // Shift-and-add avoids a generic multiplier; the sum cannot exceed 10^NDIG-1.
  assign result = (acc << 3) + (acc << 1) + BW'(digit);

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int BW   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NIB_W*NDIG-1:0] bcd_in,
  output logic [BW-1:0]         bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int            CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t                  state, state_nxt;
  logic [NIB_W*NDIG-1:0]   operand;
  logic [BW-1:0]           acc, acc_nxt;
  logic [CW-1:0]           cnt;
  logic                    bad_nibble;
  logic                    accept;
  logic                    last_digit;

  // The operand shifts left each CONV cycle, so the current digit is always the top nibble.
  bcd_mac10 #(.BW(BW)) u_mac (
    .acc    (acc),
    .digit  (operand[NIB_W*NDIG-1 -: NIB_W]),
    .result (acc_nxt)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bad_nibble = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[i*NIB_W +: NIB_W] > BCD_MAX) bad_nibble = 1'b1;
    end
  end

  assign accept     = start && (state != CONV);
  assign last_digit = (cnt == LAST);
  assign busy       = (state == CONV);
  assign done       = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = bad_nibble ? DONE : CONV;
      CONV:    if (last_digit) state_nxt = DONE;
      DONE:    state_nxt = accept ? (bad_nibble ? DONE : CONV) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand <= '0;
      acc     <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      operand <= bcd_in;
      acc     <= '0;
      cnt     <= '0;
      err     <= bad_nibble;
      if (bad_nibble) bin_out <= '0;
    end else if (state == CONV) begin
      operand <= operand << NIB_W;
      acc     <= acc_nxt;
      cnt     <= cnt + CW'(1);
      if (last_digit) bin_out <= acc_nxt;
    end
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NDIG, default 4: number of packed BCD digits accepted per conversion.
REQ-002 The block SHALL have parameter BW, default 14: binary result width; legal only when 10^NDIG-1 < 2^BW.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: request a conversion of bcd_in.
REQ-006 The block SHALL have port bcd_in, input, 4*NDIG: packed BCD operand, most significant digit in the top nibble.
REQ-007 The block SHALL have port bin_out, output, BW: binary result, registered.
REQ-008 The block SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse marking bin_out/err valid.
REQ-010 The block SHALL have port err, output, 1: last request contained a nibble greater than 9.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, CONV and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL capture bcd_in into an operand register, clear the accumulator and digit counter, clear err, and move to CONV.
REQ-013 At capture, if any nibble of bcd_in exceeds 9, the FSM SHALL go to DONE instead, with err=1 and bin_out=0, so done rises exactly 1 cycle after the start edge.
REQ-014 Each CONV cycle SHALL compute acc <= acc*10 + digit, taking digits from most to least significant, with one digit per cycle.
REQ-015 acc*10 SHALL be formed as (acc<<3)+(acc<<1) at BW bits; no overflow is possible for legal parameters.
REQ-016 After NDIG CONV cycles, the FSM SHALL load bin_out with acc and enter DONE; done=1 therefore occurs NDIG+1 cycles after the start edge (5 cycles by default).
REQ-017 busy SHALL be 1 exactly in CONV, and 0 in IDLE and DONE.
REQ-018 done SHALL be 1 only in DONE; DONE SHALL last one cycle and then return to IDLE unless start=1.
REQ-019 start=1 during CONV SHALL be ignored: there is no queuing, and the operand register and accumulator are unaffected.
REQ-020 start=1 in DONE SHALL begin a new conversion (back-to-back) while done is still pulsed for the finishing one.
REQ-021 bin_out and err SHALL hold their values from the last DONE until the next DONE.
REQ-022 bcd_in SHALL be sampled only on an accepted start; changes at other times have no effect.

Reset
REQ-023 rst=1 SHALL force, asynchronously and at any time including mid-CONV: state=IDLE, bin_out=0, busy=0, done=0, err=0, accumulator=0, digit counter=0.
REQ-024 Any conversion in flight at reset SHALL be discarded, and no done pulse follows the release of reset.
REQ-025 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-026 Package bcd_pkg SHALL hold the FSM state enum (IDLE/CONV/DONE), the BCD_MAX=9 constant and the nibble width constant 4.
REQ-027 The multiply-by-10-and-add datapath SHALL be a sub-module bcd_mac10 (inputs acc[BW], digit[4]; output acc*10+digit, combinational).
REQ-028 The FSM, counter and registers SHALL remain in bcd_to_bin.

Verification
REQ-029 The bench SHALL cover: start with bcd_in=16'h0000 -> done at cycle 5, bin_out=0, err=0.
REQ-030 The bench SHALL cover: start with 16'h9999 -> done at cycle 5, bin_out=9999 (14'h270F), err=0, busy high for cycles 1-4.
REQ-031 The bench SHALL cover: start with 16'h0835 and a second start at cycle 2 carrying 16'h1111 -> bin_out=835, the second start is ignored, and done pulses once.
REQ-032 The bench SHALL cover: start with 16'h12A4 -> done at cycle 1, err=1, bin_out=0, busy never high.
REQ-033 The bench SHALL cover: start with 16'h4321, then rst pulsed at cycle 3 -> all outputs 0 immediately, no done; a subsequent start with 16'h0042 -> bin_out=42.
REQ-034 The bench SHALL cover: start with 16'h0001, then start held in the DONE cycle with 16'h0010 -> done pulses twice, 1 then 10, with no IDLE gap.
